mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_array.sv | 17 +
 rtl/mem_responder.sv | 100 ++++++++++
 tb/tb_mem_responder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and constants for mem_responder
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        RESP    = 2'd2
    } state_e;
    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_array.sv
// mem_array: word store with synchronous write and combinational read, no reset
module mem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];
    assign rdata = mem[idx];
    // store the word on a qualified write strobe
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder (IDLE -> WAIT_ST -> RESP); MEM_RANGE_CHECK_EN enables address error checking
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               idle, acc_we, bad, enter_resp, mem_we;
    logic [31:0]        acc_adr, acc_wdata, mem_rdata;
    logic [AW-1:0]      idx;
    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );
    // the access is live on the inputs in IDLE (WAIT=0 enters RESP from there), captured otherwise
    always_comb begin
        idle      = state_q == IDLE;
        acc_we    = idle ? we : we_q;
        acc_adr   = idle ? adr : adr_q;
        acc_wdata = idle ? wdata : wdata_q;
        idx       = acc_adr[AW+1:2];
`ifdef MEM_RANGE_CHECK_EN
        bad       = (acc_adr[1:0] != 2'b00) || ((acc_adr >> (AW + 2)) != 32'd0);
`else
        bad       = 1'b0;
`endif
    end
`ifndef MEM_RANGE_CHECK_EN
    logic unused_adr_bits;
    assign unused_adr_bits = ^{acc_adr[1:0], acc_adr[31:AW+2]};
`endif
    // next-state, capture and response logic; store and rdata change only on entry to RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        if (idle && req) begin
            we_d    = we;
            adr_d   = adr;
            wdata_d = wdata;
            state_d = (WAIT == 0) ? RESP : WAIT_ST;
            cnt_d   = CNT_W'((WAIT == 0) ? 0 : WAIT - 1);
        end else if (state_q == WAIT_ST) begin
            state_d = (cnt_q == '0) ? RESP : WAIT_ST;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        enter_resp = (state_d == RESP) && (state_q != RESP);
        mem_we     = enter_resp && acc_we && !bad;
        rdata_d    = (enter_resp && !acc_we) ? (bad ? ERR_PATTERN : mem_rdata) : rdata_q;
        err_d      = enter_resp && bad;
    end
    // state registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    assign rdata = rdata_q;
    assign ack   = state_q == RESP;
    assign busy  = state_q != IDLE;
    assign err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (WAIT=2 and WAIT=0 instances)
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req2 = 1'b0, we2 = 1'b0, req0 = 1'b0, we0 = 1'b0;
    logic [31:0] adr2 = '0, wdata2 = '0, adr0 = '0, wdata0 = '0;
    logic [31:0] rdata2, rdata0;
    logic        ack2, busy2, err2, ack0, busy0, err0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .WAIT(2)) d2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .adr(adr2), .wdata(wdata2),
        .rdata(rdata2), .ack(ack2), .busy(busy2), .err(err2)
    );
    mem_responder #(.DEPTH(1024), .WAIT(0)) d0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .adr(adr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one WAIT=2 access: accept edge n, ack only between n+2 and n+3
    task automatic run2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic scr, input logic exp_err, input string tag);
        req2 = 1'b1; we2 = w; adr2 = a; wdata2 = d;
        tick;
        req2 = 1'b0;
        chk({tag, " busy n"}, 32'(busy2), 32'd1);
        chk({tag, " ack n"}, 32'(ack2), 32'd0);
        if (scr) begin
            adr2 = 32'h24; wdata2 = 32'hBAD0BAD0; we2 = ~w; req2 = 1'b1;
        end
        tick;
        chk({tag, " ack n+1"}, 32'(ack2), 32'd0);
        req2 = 1'b0;
        tick;
        chk({tag, " ack n+2"}, 32'(ack2), 32'd1);
        chk({tag, " err"}, 32'(err2), 32'(exp_err));
        tick;
        chk({tag, " ack n+3"}, 32'(ack2), 32'd0);
        chk({tag, " busy n+3"}, 32'(busy2), 32'd0);
        chk({tag, " err n+3"}, 32'(err2), 32'd0);
    endtask

    initial begin
        tick;
        tick;
        chk("reset ack", 32'(ack2), 32'd0);
        chk("reset busy", 32'(busy2), 32'd0);
        chk("reset err", 32'(err2), 32'd0);
        chk("reset rdata", rdata2, 32'd0);
        rst = 1'b1;

        run2(1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, "wr10");
        chk("wr10 rdata kept", rdata2, 32'd0);
        run2(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "rd10");
        chk("rd10 rdata", rdata2, 32'h12345678);

        run2(1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0, "wr20 scr");
        run2(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "rd20");
        chk("rd20 rdata", rdata2, 32'hCAFEF00D);

        run2(1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0, "wr40");
        run2(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "rd40");
        chk("rd40 rdata", rdata2, 32'h11111111);

        req2 = 1'b1; we2 = 1'b1; adr2 = 32'h40; wdata2 = 32'h22222222;
        tick;
        req2 = 1'b0;
        tick;
        chk("abort busy before rst", 32'(busy2), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort ack", 32'(ack2), 32'd0);
        chk("abort busy", 32'(busy2), 32'd0);
        chk("abort rdata", rdata2, 32'd0);
        tick;
        chk("abort ack held", 32'(ack2), 32'd0);
        rst = 1'b1;
        tick;
        chk("abort ack after", 32'(ack2), 32'd0);
        run2(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, "rd40 post");
        chk("rd40 post rdata", rdata2, 32'h11111111);

`ifdef MEM_RANGE_CHECK_EN
        run2(1'b0, 32'h13, 32'h0, 1'b0, 1'b1, "rd13 bad");
        chk("rd13 rdata", rdata2, 32'hDEADBEEF);
        run2(1'b1, 32'h0, 32'h00000055, 1'b0, 1'b0, "wr0");
        run2(1'b1, 32'h1000, 32'h00000077, 1'b0, 1'b1, "wr1000 bad");
        chk("wr1000 rdata kept", rdata2, 32'hDEADBEEF);
        run2(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "rd0");
        chk("rd0 rdata", rdata2, 32'h00000055);
`else
        run2(1'b1, 32'h1004, 32'h000000A5, 1'b0, 1'b0, "wr1004");
        run2(1'b0, 32'h4, 32'h0, 1'b0, 1'b0, "rd4 wrap");
        chk("rd4 rdata", rdata2, 32'h000000A5);
`endif

        req0 = 1'b1; we0 = 1'b1; adr0 = 32'h8; wdata0 = 32'hABCD0001;
        tick;
        chk("w0 wr8 ack", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick;
        chk("w0 wr8 ack end", 32'(ack0), 32'd0);
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'hC; wdata0 = 32'hABCD0002;
        tick;
        req0 = 1'b0;
        tick;
        req0 = 1'b1; we0 = 1'b0; adr0 = 32'h8;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (i == 0) adr0 = 32'hC;
            chk($sformatf("w0 b2b ack %0d", i), 32'(ack0), 32'(i % 2 == 0));
            chk($sformatf("w0 b2b busy %0d", i), 32'(busy0), 32'(i % 2 == 0));
            chk($sformatf("w0 b2b err %0d", i), 32'(err0), 32'd0);
            chk($sformatf("w0 b2b rdata %0d", i), rdata0, (i < 2) ? 32'hABCD0001 : 32'hABCD0002);
        end
        req0 = 1'b0;
        tick;
        tick;
        chk("w0 idle busy", 32'(busy0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
